// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : 11-bit UART frame transmitter (start, 8 data LSB first, parity,
//            stop) paced by an externally generated one-cycle baud_tick.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_frame #(
   parameter int PARITY_ODD = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       baud_tick,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] c_st_idle    = 2'd0;
   localparam logic [1:0] c_st_sync    = 2'd1;
   localparam logic [1:0] c_st_send    = 2'd2;
   localparam logic [1:0] c_st_done    = 2'd3;
   localparam logic [3:0] c_last_bit   = 4'd10;
   localparam logic       c_parity_inv = (PARITY_ODD != 0);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [10:0] r_shift;
   logic [3:0]  r_bit_cnt;
   logic        w_parity;
   logic        w_accept;
   logic        w_shift_en;

   assign w_parity   = (^tx_data) ^ c_parity_inv;
   assign w_accept   = (r_state == c_st_idle) && tx_start;
   assign w_shift_en = (r_state == c_st_send) && baud_tick && (r_bit_cnt < c_last_bit);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // SYNC waits for a tick so the start bit is aligned to a bit-period boundary.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: if (tx_start) w_state_nxt = c_st_sync;
         c_st_sync: if (baud_tick) w_state_nxt = c_st_send;
         c_st_send: if (baud_tick && (r_bit_cnt == c_last_bit)) w_state_nxt = c_st_done;
         c_st_done: w_state_nxt = c_st_idle;
         default:   w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         c_st_sync: busy = 1'b1;
         c_st_send: begin
            tx   = r_shift[0];
            busy = 1'b1;
         end
         c_st_done: done = 1'b1;
         default: ;
      endcase
   end

   // Frame is captured whole, so later tx_data changes cannot reach the line.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift   <= '1;
         r_bit_cnt <= '0;
      end else if (w_accept) begin
         r_shift   <= {1'b1, w_parity, tx_data, 1'b0};
         r_bit_cnt <= '0;
      end else if (w_shift_en) begin
         r_shift   <= {1'b1, r_shift[10:1]};
         r_bit_cnt <= r_bit_cnt + 4'd1;
      end
   end

endmodule
`default_nettype wire
